// File: rtl/edge_sync_pkg.sv
// edge_sync_pkg: shared constants and types for the edge_sync_filt input conditioner.
//   DEF_*   : default parameter values used by edge_sync_chan / edge_sync_filt
//   edge_t  : {rise, fall} pair for consumers of per-channel edge pulses
//   cnt_w() : width of the per-channel stability counter for a given FILT_LEN
package edge_sync_pkg;

    localparam int unsigned DEF_WIDTH     = 1;
    localparam int unsigned DEF_STAGES    = 2;
    localparam int unsigned DEF_FILT_LEN  = 4;
    localparam logic        DEF_RESET_VAL = 1'b0;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    // Counter only needs to reach FILT_LEN-1; keep at least one bit so
    // FILT_LEN=1 still has a legal (always-zero) counter.
    function automatic int unsigned cnt_w(input int unsigned filt_len);
        return (filt_len <= 1) ? 1 : $clog2(filt_len);
    endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// edge_sync_chan: one channel of the async-input conditioner.
//   sync chain (STAGES flops) -> stability filter (FILT_LEN cycles) -> out
//   -> rise/fall single-cycle pulses derived from out and its delayed copy.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in                   : asynchronous raw input
//   out                  : synchronised, filtered level
//   rise, fall           : one-cycle pulses on out 0->1 / 1->0
//   evt_clr              : clear sticky flags        (EDGE_SYNC_STICKY_EN only)
//   rise_seen, fall_seen : sticky edge flags         (EDGE_SYNC_STICKY_EN only)
// Optional feature macro: EDGE_SYNC_STICKY_EN
module edge_sync_chan
    import edge_sync_pkg::*;
#(
    parameter int unsigned STAGES    = DEF_STAGES,
    parameter int unsigned FILT_LEN  = DEF_FILT_LEN,
    parameter logic        RESET_VAL = DEF_RESET_VAL
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
`ifdef EDGE_SYNC_STICKY_EN
    ,
    input  logic evt_clr,
    output logic rise_seen,
    output logic fall_seen
`endif
);

    localparam int unsigned    CW       = cnt_w(FILT_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_LEN - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              out_dly_q, out_dly_d;
    logic              synced;
    edge_t             edge_s;

    always_comb begin
        // Pure shift: nothing combinational between synchroniser flops.
        sync_d    = {sync_q[STAGES-2:0], in};
        synced    = sync_q[STAGES-1];
        cnt_d     = '0;
        out_d     = out_q;
        out_dly_d = out_q;
        // Any cycle where synced matches out leaves cnt_d at zero, so a
        // glitch shorter than FILT_LEN never completes the count.
        if (synced != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= {STAGES{RESET_VAL}};
            cnt_q     <= '0;
            out_q     <= RESET_VAL;
            out_dly_q <= RESET_VAL;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_dly_q <= out_dly_d;
        end
    end

    always_comb begin
        edge_s.rise = out_q & ~out_dly_q;
        edge_s.fall = ~out_q & out_dly_q;
    end

    assign out  = out_q;
    assign rise = edge_s.rise;
    assign fall = edge_s.fall;

`ifdef EDGE_SYNC_STICKY_EN
    logic rise_seen_q, rise_seen_d;
    logic fall_seen_q, fall_seen_d;

    // Set term is OR'd after masking, so a same-cycle edge beats evt_clr.
    always_comb begin
        rise_seen_d = edge_s.rise | (rise_seen_q & ~evt_clr);
        fall_seen_d = edge_s.fall | (fall_seen_q & ~evt_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_seen_q <= 1'b0;
            fall_seen_q <= 1'b0;
        end else begin
            rise_seen_q <= rise_seen_d;
            fall_seen_q <= fall_seen_d;
        end
    end

    assign rise_seen = rise_seen_q;
    assign fall_seen = fall_seen_q;
`endif

endmodule

// File: rtl/edge_sync_filt.sv
// edge_sync_filt: multi-channel async-input conditioner (synchroniser,
// glitch filter, rise/fall pulse detection), WIDTH independent channels.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in      [WIDTH]      : asynchronous raw inputs
//   out     [WIDTH]      : synchronised, filtered levels
//   rise    [WIDTH]      : one-cycle pulse, out went 0->1
//   fall    [WIDTH]      : one-cycle pulse, out went 1->0
//   evt_clr [WIDTH]      : clear sticky flags        (EDGE_SYNC_STICKY_EN only)
//   rise_seen/fall_seen  : sticky edge flags         (EDGE_SYNC_STICKY_EN only)
// Optional feature macro: EDGE_SYNC_STICKY_EN
module edge_sync_filt
    import edge_sync_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned STAGES    = DEF_STAGES,
    parameter int unsigned FILT_LEN  = DEF_FILT_LEN,
    parameter logic        RESET_VAL = DEF_RESET_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef EDGE_SYNC_STICKY_EN
    ,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] rise_seen,
    output logic [WIDTH-1:0] fall_seen
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : gen_chan
        edge_sync_chan #(
            .STAGES    (STAGES),
            .FILT_LEN  (FILT_LEN),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .in        (in[i]),
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
`ifdef EDGE_SYNC_STICKY_EN
            ,
            .evt_clr   (evt_clr[i]),
            .rise_seen (rise_seen[i]),
            .fall_seen (fall_seen[i])
`endif
        );
    end

endmodule

// File: tb/tb_edge_sync_filt.sv
// Bench for edge_sync_filt: two configurations side by side
//   cfg0: WIDTH=4 STAGES=2 FILT_LEN=4 RESET_VAL=0
//   cfg1: WIDTH=4 STAGES=2 FILT_LEN=1 RESET_VAL=1
// Each config has a history-based model compared on every negedge, plus
// directed literal expectations in the stimulus.
module tb_edge_sync_filt;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int HMAX = 1023;

    logic         clk;
    logic         reset;
    logic [W-1:0] din   [2];
    logic [W-1:0] dclr  [2];
    logic [W-1:0] dout  [2];
    logic [W-1:0] drise [2];
    logic [W-1:0] dfall [2];
    logic [W-1:0] drs   [2];
    logic [W-1:0] dfs   [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_cfg
        localparam int   F  = (g == 0) ? 4 : 1;
        localparam logic RV = (g == 0) ? 1'b0 : 1'b1;

        edge_sync_filt #(
            .WIDTH     (W),
            .STAGES    (S),
            .FILT_LEN  (F),
            .RESET_VAL (RV)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .in        (din[g]),
            .out       (dout[g]),
            .rise      (drise[g]),
            .fall      (dfall[g])
`ifdef EDGE_SYNC_STICKY_EN
            ,
            .evt_clr   (dclr[g]),
            .rise_seen (drs[g]),
            .fall_seen (dfs[g])
`endif
        );

`ifndef EDGE_SYNC_STICKY_EN
        assign drs[g] = '0;
        assign dfs[g] = '0;
`endif

        // Model: hist[e] = level the synchroniser captured at edge e; the
        // filter at edge e looks at hist[e-S]. out flips once FILT_LEN
        // consecutive filter-visible samples since its last change (or
        // reset) all disagree with it.
        logic [W-1:0] hist [0:HMAX];
        logic [W-1:0] out_m, outd_m, rs_m, fs_m, rnow, fnow;
        int           lastchg [W];
        int           cyc;
        bit           armed;
        bit           ok;

        initial begin
            for (int k = 0; k <= HMAX; k++) hist[k] = {W{RV}};
            cyc   = 16;
            armed = 1'b0;
            out_m = {W{RV}};
            outd_m = {W{RV}};
            rs_m  = '0;
            fs_m  = '0;
            for (int c = 0; c < W; c++) lastchg[c] = 0;
        end

        always @(posedge clk) begin
            rnow = out_m & ~outd_m;
            fnow = ~out_m & outd_m;
            if (reset) begin
                for (int k = 0; k < S; k++) hist[cyc-k] = {W{RV}};
                out_m  = {W{RV}};
                outd_m = {W{RV}};
                rs_m   = '0;
                fs_m   = '0;
                for (int c = 0; c < W; c++) lastchg[c] = cyc;
                armed  = 1'b1;
            end else begin
                hist[cyc] = din[g];
                outd_m    = out_m;
                rs_m      = rnow | (rs_m & ~dclr[g]);
                fs_m      = fnow | (fs_m & ~dclr[g]);
                for (int c = 0; c < W; c++) begin
                    if (cyc >= lastchg[c] + F) begin
                        ok = 1'b1;
                        for (int j = 0; j < F; j++)
                            if (hist[cyc-j-S][c] == out_m[c]) ok = 1'b0;
                        if (ok) begin
                            out_m[c]   = ~out_m[c];
                            lastchg[c] = cyc;
                        end
                    end
                end
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (armed) begin
                chk($sformatf("cfg%0d out", g),  dout[g],  out_m);
                chk($sformatf("cfg%0d rise", g), drise[g], out_m & ~outd_m);
                chk($sformatf("cfg%0d fall", g), dfall[g], ~out_m & outd_m);
`ifdef EDGE_SYNC_STICKY_EN
                chk($sformatf("cfg%0d rise_seen", g), drs[g], rs_m);
                chk($sformatf("cfg%0d fall_seen", g), dfs[g], fs_m);
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset   = 1'b1;
        din[0]  = 4'hF;
        din[1]  = 4'hF;
        dclr[0] = '0;
        dclr[1] = '0;

        // Reset held 5 cycles with all inputs high.
        step(5);
        chk("t1 out in reset", dout[0], 4'h0);
        chk("t1 rise in reset", drise[0], 4'h0);
        chk("t6b out in reset", dout[1], 4'hF);
        reset = 1'b0;
        step(1);
        chk("t1 out after release", dout[0], 4'h0);
        chk("t1 rise after release", drise[0], 4'h0);
        chk("t1 fall after release", dfall[0], 4'h0);
        chk("t6b fall after release", dfall[1], 4'h0);
        // One-cycle high on cfg0 after release is filtered; cfg1 ch0 goes low.
        din[0] = 4'h0;
        din[1] = 4'hE;
        step(2);
        chk("t6b out edge2", dout[1], 4'hF);
        step(1);
        chk("t6b out edge3", dout[1], 4'hE);
        chk("t6b fall edge3", dfall[1], 4'h1);
        step(1);
        chk("t6b fall cleared", dfall[1], 4'h0);
        step(8);
        chk("t1 glitch filtered", dout[0], 4'h0);

        // Test 2: ch0 rises, appears at edge 6.
        din[0] = 4'h1;
        step(5);
        chk("t2 out edge5", dout[0], 4'h0);
        step(1);
        chk("t2 out edge6", dout[0], 4'h1);
        chk("t2 rise edge6", drise[0], 4'h1);
        step(1);
        chk("t2 rise edge7", drise[0], 4'h0);
        chk("t2 out edge7", dout[0], 4'h1);

        // Test 3: 3-cycle pulse filtered, 4-cycle pulse passes.
        din[0][1] = 1'b1;
        step(3);
        din[0][1] = 1'b0;
        step(10);
        chk("t3 short pulse", dout[0], 4'h1);
        din[0][1] = 1'b1;
        step(4);
        din[0][1] = 1'b0;
        step(2);
        chk("t3 long pulse out", dout[0], 4'h3);
        chk("t3 long pulse rise", drise[0], 4'h2);
        step(12);

        // Test 4: simultaneous rise on ch2 and fall on ch3.
        din[0][3] = 1'b1;
        step(10);
        chk("t4 ch3 high", dout[0], 4'h9);
        din[0][2] = 1'b1;
        din[0][3] = 1'b0;
        step(6);
        chk("t4 rise", drise[0], 4'h4);
        chk("t4 fall", dfall[0], 4'h8);

        // Test 5: reset mid-filter discards progress.
        din[0][0] = 1'b0;
        step(10);
        din[0][0] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5 out after reset", dout[0], 4'h0);
        step(5);
        chk("t5 ch0 edge5", dout[0] & 4'h1, 4'h0);
        step(1);
        chk("t5 ch0 edge6", dout[0] & 4'h1, 4'h1);
        chk("t5 rise ch0", drise[0] & 4'h1, 4'h1);

`ifdef EDGE_SYNC_STICKY_EN
        // Test 6: sticky flags, set beats simultaneous clear.
        step(3);
        dclr[0] = 4'hF;
        step(1);
        dclr[0] = 4'h0;
        chk("t6 rs cleared", drs[0], 4'h0);
        chk("t6 fs cleared", dfs[0], 4'h0);
        din[0][0] = 1'b0;
        step(8);
        din[0][0] = 1'b1;
        step(6);
        chk("t6 rise now", drise[0] & 4'h1, 4'h1);
        chk("t6 rs before", drs[0] & 4'h1, 4'h0);
        dclr[0][0] = 1'b1;
        step(1);
        chk("t6 set wins", drs[0] & 4'h1, 4'h1);
        step(1);
        chk("t6 clear", drs[0] & 4'h1, 4'h0);
        dclr[0][0] = 1'b0;
`endif

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
